// File: rtl/ram_tp_arbiter.sv
// ram_tp_arbiter: round-robin sharing of a 1W/1R byte-masked RAM
// between NUM_REQ requesters, with same-cycle write-to-read forwarding.
module ram_tp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = DATA_WIDTH / 8,
  localparam int PTR_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req_wr_valid,
  output logic [NUM_REQ-1:0]               req_wr_ready,
  input  logic [NUM_REQ*BWEN_WIDTH-1:0]    req_wr_bwen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
  input  logic [NUM_REQ-1:0]               req_rd_valid,
  output logic [NUM_REQ-1:0]               req_rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd_addr,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             ram_cen,
  output logic                             ram_wen,
  output logic [BWEN_WIDTH-1:0]            ram_bwen,
  output logic [ADDR_WIDTH-1:0]            ram_waddr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_ren,
  output logic [ADDR_WIDTH-1:0]            ram_raddr,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  // Two passes: indices above ptr first, then wrap to those at or below it.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   vld,
    input logic [PTR_WIDTH-1:0] ptr
  );
    logic [NUM_REQ-1:0] g;
    logic               hit;
    g   = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && vld[i] && i > int'(ptr)) begin
        g[i] = 1'b1;
        hit  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && vld[i] && i <= int'(ptr)) begin
        g[i] = 1'b1;
        hit  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PTR_WIDTH-1:0] enc(
    input logic [NUM_REQ-1:0] oh
  );
    logic [PTR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_WIDTH'(i);
    end
    return idx;
  endfunction

  logic                  gate;
  logic [NUM_REQ-1:0]    wr_gnt;
  logic [NUM_REQ-1:0]    rd_gnt;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [NUM_REQ-1:0]    rsp_q;
  logic [BWEN_WIDTH-1:0] byp_mask;
  logic [DATA_WIDTH-1:0] byp_data;
  logic                  byp_hit;

  // Reset low also masks grants so RAM controls are quiet in reset.
  assign gate = enable & reset_n;

  assign wr_gnt = rr_pick(req_wr_valid & {NUM_REQ{gate}}, wr_ptr);
  assign rd_gnt = rr_pick(req_rd_valid & {NUM_REQ{gate}}, rd_ptr);

  assign req_wr_ready = wr_gnt;
  assign req_rd_ready = rd_gnt;

  assign ram_wen = |wr_gnt;
  assign ram_ren = |rd_gnt;
  assign ram_cen = ram_wen | ram_ren;

  always_comb begin
    ram_bwen  = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        ram_bwen  = ram_bwen  | req_wr_bwen[i*BWEN_WIDTH +: BWEN_WIDTH];
        ram_waddr = ram_waddr | req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = ram_wdata | req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt[i]) begin
        ram_raddr = ram_raddr | req_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign byp_hit = ram_wen & ram_ren & (ram_waddr == ram_raddr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= PTR_WIDTH'(NUM_REQ - 1);
      rd_ptr   <= PTR_WIDTH'(NUM_REQ - 1);
      rsp_q    <= '0;
      byp_mask <= '0;
      byp_data <= '0;
    end else begin
      if (ram_wen) wr_ptr <= enc(wr_gnt);
      if (ram_ren) rd_ptr <= enc(rd_gnt);
      rsp_q <= rd_gnt;
      if (byp_hit) begin
        byp_mask <= ram_bwen;
        byp_data <= ram_wdata;
      end else begin
        byp_mask <= '0;
      end
    end
  end

  assign rsp_valid = rsp_q;

  // RAM returns the pre-write word; overlay bytes written alongside the read.
  always_comb begin
    rsp_data = ram_rdata;
    for (int k = 0; k < BWEN_WIDTH; k++) begin
      if (byp_mask[k]) rsp_data[8*k +: 8] = byp_data[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_ram_tp_arbiter.sv
// tb_ram_tp_arbiter: directed + random stimulus against a
// transaction-level model of the shared RAM and round-robin grants.
module tb_ram_tp_arbiter;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int N = 2;
  localparam int AW = 4;
  localparam int BW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n;
  logic            enable;
  logic [N-1:0]    req_wr_valid;
  logic [N-1:0]    req_wr_ready;
  logic [N*BW-1:0] req_wr_bwen;
  logic [N*AW-1:0] req_wr_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]    req_rd_valid;
  logic [N-1:0]    req_rd_ready;
  logic [N*AW-1:0] req_rd_addr;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_cen;
  logic            ram_wen;
  logic [BW-1:0]   ram_bwen;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_ren;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_rdata = '0;

  ram_tp_arbiter #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(N)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_wr_bwen(req_wr_bwen), .req_wr_addr(req_wr_addr),
    .req_wr_data(req_wr_data),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .req_rd_addr(req_rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // RAM with registered read returning the old word
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    logic [DW-1:0] w;
    if (ram_cen && ram_wen) begin
      w = mem[ram_waddr];
      for (int b = 0; b < BW; b++)
        if (ram_bwen[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[ram_waddr] <= w;
    end
    if (ram_cen && ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  int            m_wptr = N - 1;
  int            m_rptr = N - 1;
  bit            pend = 1'b0;
  int            pend_own = 0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clock) begin
    int            gw;
    int            gr;
    logic [N-1:0]  ew;
    logic [N-1:0]  er;
    logic [N-1:0]  erv;
    logic [BW-1:0] bw;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    if (!reset_n) begin
      check("rst_ready", 64'({req_wr_ready, req_rd_ready}), 64'(0));
      check("rst_ram", 64'({ram_cen, ram_wen, ram_ren}), 64'(0));
      check("rst_rsp", 64'(rsp_valid), 64'(0));
      m_wptr = N - 1;
      m_rptr = N - 1;
      pend = 1'b0;
    end else begin
      erv = '0;
      if (pend) erv[pend_own] = 1'b1;
      check("rsp_valid", 64'(rsp_valid), 64'(erv));
      if (pend) check("rsp_data", 64'(rsp_data), 64'(pend_data));
      gw = enable ? pick(req_wr_valid, m_wptr) : -1;
      gr = enable ? pick(req_rd_valid, m_rptr) : -1;
      ew = '0; er = '0; bw = '0; wa = '0; wd = '0; ra = '0;
      if (gw >= 0) begin
        ew[gw] = 1'b1;
        bw = req_wr_bwen[gw*BW +: BW];
        wa = req_wr_addr[gw*AW +: AW];
        wd = req_wr_data[gw*DW +: DW];
      end
      if (gr >= 0) begin
        er[gr] = 1'b1;
        ra = req_rd_addr[gr*AW +: AW];
      end
      check("wr_ready", 64'(req_wr_ready), 64'(ew));
      check("rd_ready", 64'(req_rd_ready), 64'(er));
      check("ram_bus",
        64'({ram_cen, ram_wen, ram_ren, ram_bwen, ram_waddr, ram_wdata, ram_raddr}),
        64'({(gw >= 0 || gr >= 0), (gw >= 0), (gr >= 0), bw, wa, wd, ra}));
      if (gw >= 0) begin
        m_wptr = gw;
        for (int b = 0; b < BW; b++)
          if (bw[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      end
      pend = (gr >= 0);
      if (gr >= 0) begin
        m_rptr = gr;
        pend_own = gr;
        pend_data = ref_mem[ra];
      end
    end
  end

  task automatic clr();
    req_wr_valid = '0; req_rd_valid = '0;
    req_wr_bwen = '0; req_wr_addr = '0; req_wr_data = '0;
    req_rd_addr = '0;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_wr_valid[i] = 1'b1;
    req_wr_addr[i*AW +: AW] = a;
    req_wr_data[i*DW +: DW] = d;
    req_wr_bwen[i*BW +: BW] = b;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    req_rd_valid[i] = 1'b1;
    req_rd_addr[i*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] t6_word(input int a);
    return (a < 3) ? (32'hC0DE_0000 | DW'(a)) : 32'hA5A5_A5A5;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset_n = 1'b0;
    enable = 1'b1;
    clr();
    req_wr_valid = '1;
    req_rd_valid = '1;
    #2;
    check("lit_rst_ready", 64'({req_wr_ready, req_rd_ready}), 64'(0));
    check("lit_rst_cen", 64'(ram_cen), 64'(0));
    step(); step();
    clr();
    reset_n = 1'b1;

    // write then read addr 3
    wr(0, 4'd3, 32'hA5A5_A5A5, 4'hF);
    #2 check("lit_t1_wready", 64'(req_wr_ready), 64'(2'b01));
    step(); clr();
    step();
    rd(1, 4'd3);
    #2 check("lit_t1_rready", 64'(req_rd_ready), 64'(2'b10));
    step(); clr();
    #2 check("lit_t1_rsp", 64'(rsp_valid), 64'(2'b10));
    check("lit_t1_data", 64'(rsp_data), 64'(32'hA5A5_A5A5));
    step();
    #2 check("lit_t1_rsp_once", 64'(rsp_valid), 64'(0));

    // rotation from reset pointers
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr(0, 4'd8, $urandom, 4'hF);
      wr(1, 4'd9, $urandom, 4'hF);
      rd(0, 4'd8);
      rd(1, 4'd9);
      #2;
      check("lit_rot_wr", 64'(req_wr_ready), 64'((k % 2) ? 2'b10 : 2'b01));
      check("lit_rot_rd", 64'(req_rd_ready), 64'((k % 2) ? 2'b10 : 2'b01));
      step();
    end
    clr();

    // partial-byte forwarding
    wr(0, 4'd5, 32'h1122_3344, 4'hF);
    step(); clr();
    wr(0, 4'd5, 32'hAABB_CCDD, 4'b0101);
    rd(1, 4'd5);
    step(); clr();
    #2 check("lit_fwd_rsp", 64'(rsp_valid), 64'(2'b10));
    check("lit_fwd_data", 64'(rsp_data), 64'(32'h11BB_33DD));
    step();

    // enable falls after an accepted read
    rd(0, 4'd3);
    #2 check("lit_en_rready", 64'(req_rd_ready), 64'(2'b01));
    step();
    enable = 1'b0;
    req_wr_valid = '1;
    req_rd_valid = '1;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("lit_en_ready", 64'({req_wr_ready, req_rd_ready}), 64'(0));
      check("lit_en_cen", 64'(ram_cen), 64'(0));
      if (k == 0) begin
        check("lit_en_rsp", 64'(rsp_valid), 64'(2'b01));
        check("lit_en_data", 64'(rsp_data), 64'(32'hA5A5_A5A5));
      end
      step();
    end
    clr();
    enable = 1'b1;

    // reset drops a pending response
    rd(1, 4'd5);
    #2 check("lit_rr_rready", 64'(req_rd_ready), 64'(2'b10));
    step();
    reset_n = 1'b0;
    clr();
    #2 check("lit_rr_rsp", 64'(rsp_valid), 64'(0));
    step();
    reset_n = 1'b1;
    req_wr_valid = '1;
    req_rd_valid = '1;
    #2;
    check("lit_rr_wfirst", 64'(req_wr_ready), 64'(2'b01));
    check("lit_rr_rfirst", 64'(req_rd_ready), 64'(2'b01));
    step(); clr();

    // back-to-back reads by requester 0
    for (int a = 0; a < 3; a++) begin
      clr();
      wr(1, AW'(a), t6_word(a), 4'hF);
      step();
    end
    for (int a = 0; a < 4; a++) begin
      clr();
      rd(0, AW'(a));
      #2 check("lit_b2b_ren", 64'(ram_ren), 64'(1));
      if (a > 0) begin
        check("lit_b2b_rsp", 64'(rsp_valid), 64'(2'b01));
        check("lit_b2b_data", 64'(rsp_data), 64'(t6_word(a - 1)));
      end
      step();
    end
    clr();
    #2 check("lit_b2b_rsp", 64'(rsp_valid), 64'(2'b01));
    check("lit_b2b_data", 64'(rsp_data), 64'(t6_word(3)));
    step();

    // random traffic on a few addresses to provoke collisions
    for (int c = 0; c < 500; c++) begin
      enable = ($urandom_range(9) != 0);
      reset_n = ($urandom_range(99) != 0);
      for (int i = 0; i < N; i++) begin
        req_wr_valid[i] = 1'($urandom_range(1));
        req_rd_valid[i] = 1'($urandom_range(1));
        req_wr_addr[i*AW +: AW] = AW'($urandom_range(3));
        req_rd_addr[i*AW +: AW] = AW'($urandom_range(3));
        req_wr_data[i*DW +: DW] = $urandom;
        req_wr_bwen[i*BW +: BW] = BW'($urandom_range(15));
      end
      step();
    end
    reset_n = 1'b1;
    enable = 1'b1;
    clr();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
